// File: rtl/colour_pkg.sv
// rtl/colour_pkg.sv - shared FP32 field layout, constants and result classes for colour conversion
package colour_pkg;

    localparam int SIGN_BIT   = 31;
    localparam int EXP_MSB    = 30;
    localparam int EXP_LSB    = 23;
    localparam int FRAC_MSB   = 22;

    localparam int EXP_BIAS   = 127;
    localparam int EXP_ONE    = 127;
    localparam int SHIFT_BASE = 150;
    localparam logic [7:0] COLOUR_MAX = 8'hFF;

    typedef enum logic [2:0] {
        CLS_NORMAL,
        CLS_ZERO,
        CLS_SAT_LO,
        CLS_SAT_HI,
        CLS_NAN
    } cls_e;

endpackage

// File: rtl/fp32_unpack.sv
// rtl/fp32_unpack.sv - combinational FP32 field extraction and colour result classification
module fp32_unpack
    import colour_pkg::*;
(
    input  logic [31:0] data_i,
    output logic [7:0]  exp_o,
    output logic [23:0] mant_o,
    output cls_e        cls_o
);

    logic        sign;
    logic [22:0] frac;

    assign sign   = data_i[SIGN_BIT];
    assign exp_o  = data_i[EXP_MSB:EXP_LSB];
    assign frac   = data_i[FRAC_MSB:0];
    assign mant_o = {exp_o != 8'd0, frac};

    // Exactly 1.0 stays on the arithmetic path: it lands on 255 unsaturated.
    always_comb begin
        cls_o = CLS_NORMAL;
        if (exp_o == 8'hFF && frac != 23'd0) begin
            cls_o = CLS_NAN;
        end else if (sign) begin
            cls_o = (exp_o == 8'd0 && frac == 23'd0) ? CLS_ZERO : CLS_SAT_LO;
        end else if (exp_o > 8'(EXP_ONE)) begin
            cls_o = CLS_SAT_HI;
        end else if (exp_o == 8'(EXP_ONE) && frac != 23'd0) begin
            cls_o = CLS_SAT_HI;
        end else if (exp_o == 8'd0) begin
            cls_o = CLS_ZERO;
        end
    end

endmodule

// File: rtl/colour_float_to_int.sv
// rtl/colour_float_to_int.sv - 3-stage FP32 [0,1] colour channel to 8-bit round(f*255) converter
module colour_float_to_int
    import colour_pkg::*;
#(
    parameter logic [7:0] NAN_VALUE     = 8'h00,
    parameter logic [7:0] INF_POS_VALUE = 8'hFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic [7:0]  data_o,
    output logic        sat_o,
    output logic        valid_o,
    input  logic        ready_i
);

    logic        en;

    logic [7:0]  s1_exp_d;
    logic [23:0] s1_mant_d;
    cls_e        s1_cls_d;
    logic [7:0]  s1_sh_d;

    logic        s1_valid_q;
    logic [23:0] s1_mant_q;
    cls_e        s1_cls_q;
    logic [7:0]  s1_sh_q;

    logic [31:0] s2_prod_d;
    logic        s2_valid_q;
    logic [31:0] s2_prod_q;
    cls_e        s2_cls_q;
    logic [7:0]  s2_sh_q;

    logic [32:0] rounded;
    logic [7:0]  out_data_d;
    logic        out_sat_d;
    logic        out_valid_q;
    logic [7:0]  out_data_q;
    logic        out_sat_q;

    assign en      = !out_valid_q || ready_i;
    assign ready_o = en;
    assign valid_o = out_valid_q;
    assign data_o  = out_data_q;
    assign sat_o   = out_sat_q;

    fp32_unpack u_unpack (
        .data_i (data_i),
        .exp_o  (s1_exp_d),
        .mant_o (s1_mant_d),
        .cls_o  (s1_cls_d)
    );

    assign s1_sh_d   = 8'(SHIFT_BASE) - s1_exp_d;
    assign s2_prod_d = ({8'd0, s1_mant_q} << 8) - {8'd0, s1_mant_q};

    // Half-up rounding: shift by sh-1, add one, drop the last bit.
    always_comb begin
        out_data_d = 8'h00;
        out_sat_d  = 1'b0;
        rounded    = 33'd0;
        case (s2_cls_q)
            CLS_NORMAL: begin
                if (s2_sh_q <= 8'd32) begin
                    rounded = (({1'b0, s2_prod_q} >> (s2_sh_q - 8'd1)) + 33'd1) >> 1;
                    if (rounded > 33'(COLOUR_MAX)) begin
                        out_data_d = COLOUR_MAX;
                        out_sat_d  = 1'b1;
                    end else begin
                        out_data_d = rounded[7:0];
                    end
                end
            end
            CLS_SAT_LO: out_sat_d = 1'b1;
            CLS_SAT_HI: begin
                out_data_d = INF_POS_VALUE;
                out_sat_d  = 1'b1;
            end
            CLS_NAN: begin
                out_data_d = NAN_VALUE;
                out_sat_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_mant_q   <= 24'd0;
            s1_cls_q    <= CLS_ZERO;
            s1_sh_q     <= 8'd0;
            s2_valid_q  <= 1'b0;
            s2_prod_q   <= 32'd0;
            s2_cls_q    <= CLS_ZERO;
            s2_sh_q     <= 8'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_sat_q   <= 1'b0;
        end else if (en) begin
            s1_valid_q  <= valid_i;
            s1_mant_q   <= s1_mant_d;
            s1_cls_q    <= s1_cls_d;
            s1_sh_q     <= s1_sh_d;
            s2_valid_q  <= s1_valid_q;
            s2_prod_q   <= s2_prod_d;
            s2_cls_q    <= s1_cls_q;
            s2_sh_q     <= s1_sh_q;
            out_valid_q <= s2_valid_q;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_colour_float_to_int.sv
// tb/tb_colour_float_to_int.sv - self-checking bench for colour_float_to_int
module tb_colour_float_to_int;

    localparam logic [7:0] NAN_V = 8'h00;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] data_i = 32'd0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [7:0]  data_o;
    logic        sat_o;
    logic        valid_o;
    logic        ready_i = 1'b1;

    colour_float_to_int dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .sat_o   (sat_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       s;
        int         acc;
        bit         lat;
        string      nm;
    } exp_t;

    typedef struct {
        logic [31:0] f;
        logic [7:0]  d;
        logic        s;
        string       nm;
    } vec_t;

    exp_t  sb[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    ready_mode = 0;
    logic [7:0] cur_ed = 8'd0;
    logic  cur_es = 1'b0;
    bit    cur_use = 1'b0;
    bit    cur_lat = 1'b0;
    string cur_nm = "rand";

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        ready_i = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference: decide the class from the sign/exponent rules, then evaluate round(v*255) in real arithmetic.
    function automatic void model(input logic [31:0] f, output logic [7:0] d, output logic s);
        int  e;
        int  frac;
        int  r;
        real v;
        e    = int'(f[30:23]);
        frac = int'(f[22:0]);
        d = 8'h00;
        s = 1'b0;
        if (e == 255 && frac != 0) begin
            d = NAN_V;
            s = 1'b1;
        end else if (f[31]) begin
            s = !(e == 0 && frac == 0);
        end else if (e >= 127) begin
            d = 8'hFF;
            s = !(e == 127 && frac == 0);
        end else if (e != 0) begin
            v = 8388608.0 + real'(frac);
            for (int i = 0; i < 150 - e; i++) v = v / 2.0;
            r = $rtoi($floor(v * 255.0 + 0.5));
            d = (r > 255) ? 8'hFF : 8'(r);
            s = (r > 255);
        end
    endfunction

    // Correctly rounded FP32 encoding of k/255.
    function automatic logic [31:0] tbl(input int k);
        longint m;
        int     sh;
        if (k == 0) return 32'd0;
        sh = 24;
        while ((longint'(k) << sh) < (longint'(255) << 23)) sh++;
        m = ((longint'(k) << sh) + 127) / 255;
        return {1'b0, 8'(150 - sh), m[22:0]};
    endfunction

    function automatic logic [31:0] rnd_float();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: return r;
            1: return {1'b0, 8'($urandom_range(100, 126)), r[22:0]};
            2: return tbl(int'($urandom_range(0, 254)));
            default: return {r[31], 8'($urandom_range(125, 128)), (r[0] ? 23'd0 : r[22:0])};
        endcase
    endfunction

    logic       prev_stall = 1'b0;
    logic [7:0] prev_d;
    logic       prev_s;
    logic [7:0] m_d;
    logic       m_s;
    exp_t       e_cur;

    always @(negedge clk) begin
        if (rst_i) begin
            prev_stall = 1'b0;
        end else begin
            check("ready_o", 32'(ready_o), 32'(!valid_o || ready_i));
            if (prev_stall) begin
                check("hold_valid", 32'(valid_o), 32'd1);
                check("hold_data", 32'(data_o), 32'(prev_d));
                check("hold_sat", 32'(sat_o), 32'(prev_s));
            end
            if (valid_i && ready_o) begin
                if (cur_use) begin
                    m_d = cur_ed;
                    m_s = cur_es;
                end else begin
                    model(data_i, m_d, m_s);
                end
                sb.push_back('{d: m_d, s: m_s, acc: cyc, lat: cur_lat, nm: cur_nm});
            end
            if (valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output got=%0h exp=none", data_o);
                end else begin
                    e_cur = sb.pop_front();
                    check({"data_", e_cur.nm}, 32'(data_o), 32'(e_cur.d));
                    check({"sat_", e_cur.nm}, 32'(sat_o), 32'(e_cur.s));
                    if (e_cur.lat) check({"latency_", e_cur.nm}, 32'(cyc - e_cur.acc), 32'd3);
                end
            end
            prev_stall = valid_o && !ready_i;
            prev_d = data_o;
            prev_s = sat_o;
        end
    end

    task automatic send(input logic [31:0] d, input logic [7:0] ed, input logic es, input string nm);
        int g;
        data_i  = d;
        valid_i = 1'b1;
        cur_ed  = ed;
        cur_es  = es;
        cur_nm  = nm;
        g = 0;
        @(negedge clk);
        while (!ready_o && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (!ready_o) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got=%0d exp=ready", ready_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        valid_i = 1'b0;
        for (int i = 0; i < 1000 && sb.size() != 0; i++) @(negedge clk);
        check("drain_empty", 32'(sb.size()), 32'd0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        vecs = '{
            '{32'h3f000000, 8'd128, 1'b0, "half"},
            '{32'h3f7fffff, 8'd255, 1'b0, "below_one"},
            '{32'h3f800000, 8'd255, 1'b0, "one"},
            '{32'h3b000000, 8'd0,   1'b0, "one_512th"},
            '{32'h3e800000, 8'd64,  1'b0, "quarter"},
            '{32'h7fc00000, NAN_V,  1'b1, "nan"},
            '{32'hffc00000, NAN_V,  1'b1, "neg_nan"},
            '{32'hbf000000, 8'd0,   1'b1, "neg_half"},
            '{32'h80000000, 8'd0,   1'b0, "neg_zero"},
            '{32'hff800000, 8'd0,   1'b1, "neg_inf"},
            '{32'h7f800000, 8'd255, 1'b1, "pos_inf"},
            '{32'h40000000, 8'd255, 1'b1, "two"},
            '{32'h3f800001, 8'd255, 1'b1, "above_one"},
            '{32'h00000001, 8'd0,   1'b0, "denormal"}
        };

        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("rst_valid_o", 32'(valid_o), 32'd0);
        check("rst_data_o", 32'(data_o), 32'd0);
        check("rst_sat_o", 32'(sat_o), 32'd0);
        check("rst_ready_o", 32'(ready_o), 32'd1);
        @(posedge clk);
        #1;

        cur_use = 1'b1;
        cur_lat = 1'b1;
        for (int k = 0; k < 255; k++) send(tbl(k), 8'(k), 1'b0, "roundtrip");
        drain();

        foreach (vecs[i]) send(vecs[i].f, vecs[i].d, vecs[i].s, vecs[i].nm);
        drain();

        cur_use = 1'b0;
        cur_lat = 1'b0;
        ready_mode = 1;
        for (int i = 0; i < 10; i++) send(rnd_float(), 8'd0, 1'b0, "bp10");
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                valid_i = 1'b0;
                @(posedge clk);
                #1;
            end
            send(rnd_float(), 8'd0, 1'b0, "rand");
        end
        drain();
        ready_mode = 0;
        @(posedge clk);
        #1;

        cur_use = 1'b1;
        cur_lat = 1'b1;
        send(32'h3f000000, 8'd128, 1'b0, "flushed_a");
        send(32'h3f7fffff, 8'd255, 1'b0, "flushed_b");
        valid_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        sb.delete();
        @(negedge clk);
        check("midrst_valid_o", 32'(valid_o), 32'd0);
        check("midrst_data_o", 32'(data_o), 32'd0);
        @(posedge clk);
        #1;
        send(32'h3e800000, 8'd64, 1'b0, "post_rst_a");
        send(32'h3b808081, 8'd1, 1'b0, "post_rst_b");
        drain();

        cur_use = 1'b0;
        for (int i = 0; i < 20; i++) begin
            valid_i = (i < 16 && i % 2 == 0);
            data_i  = rnd_float();
            cur_nm  = "bubble";
            @(negedge clk);
            check("bubble_valid_o", 32'(valid_o), 32'(i >= 3 && i - 3 < 16 && (i - 3) % 2 == 0));
            @(posedge clk);
            #1;
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
